// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back.
// Optional jump support is compiled in when CUNIT_JUMP_EN is defined.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MRead,
    output logic       MWrite,
    output logic       IRWrite,
    output logic       RegDs,
    output logic       MtoR,
    output logic       Urw,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] AOp,
    output logic       ill_op,
    output logic [3:0] st
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef CUNIT_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        IEXEC  = 4'd10,
`ifdef CUNIT_JUMP_EN
        IWB    = 4'd11,
        JUMP   = 4'd12
`else
        IWB    = 4'd11
`endif
    } state_t;

    state_t     state;
    state_t     next;
    logic [5:0] op_q;
    logic       ill_q;
    logic       ill_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= 6'd0;
            ill_q <= 1'b0;
        end else begin
            state <= next;
            ill_q <= ill_d;
            if (state == DECODE)
                op_q <= op;
        end
    end

    assign ill_op = ill_q;
    assign st     = state;

    always_comb begin
        next        = IDLE;
        ill_d       = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        MRead       = 1'b0;
        MWrite      = 1'b0;
        IRWrite     = 1'b0;
        RegDs       = 1'b0;
        MtoR        = 1'b0;
        Urw         = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        AOp         = 3'b000;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                MRead   = 1'b1;
                ALUSrcB = 2'b01;
                AOp     = 3'b011;
                // IR and PC advance only when the memory word actually arrives
                if (mem_rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    next    = DECODE;
                end else begin
                    next    = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                AOp     = 3'b011;
                case (op)
                    OP_RTYPE:        next = EXEC;
                    OP_LW, OP_SW:    next = MEMADR;
                    OP_BEQ:          next = BRANCH;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI: next = IEXEC;
`ifdef CUNIT_JUMP_EN
                    OP_J:            next = JUMP;
`endif
                    default: begin
                        next  = FETCH;
                        ill_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                AOp     = 3'b011;
                next    = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MRead = 1'b1;
                IorD  = 1'b1;
                next  = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MtoR = 1'b1;
                Urw  = 1'b1;
                next = FETCH;
            end
            MEMWR: begin
                MWrite = 1'b1;
                IorD   = 1'b1;
                next   = mem_rdy ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                AOp     = 3'b010;
                next    = RWB;
            end
            RWB: begin
                RegDs = 1'b1;
                Urw   = 1'b1;
                next  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                AOp         = 3'b001;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
                next        = FETCH;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ADDI: AOp = 3'b011;
                    OP_ANDI: AOp = 3'b101;
                    OP_ORI:  AOp = 3'b110;
                    OP_SLTI: AOp = 3'b100;
                    default: AOp = 3'b000;
                endcase
                next = IWB;
            end
            IWB: begin
                Urw  = 1'b1;
                next = FETCH;
            end
`ifdef CUNIT_JUMP_EN
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                next    = FETCH;
            end
`endif
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_rdy = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite;
    logic       RegDs, MtoR, Urw, ALUSrcA, ill_op;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] AOp;
    logic [3:0] st;

    int n_cmp = 0;
    int n_err = 0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_rdy(mem_rdy),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc),
        .IorD(IorD), .MRead(MRead), .MWrite(MWrite), .IRWrite(IRWrite),
        .RegDs(RegDs), .MtoR(MtoR), .Urw(Urw), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .AOp(AOp), .ill_op(ill_op), .st(st)
    );

    always #5 clk = ~clk;

    wire [21:0] all_out = {PCWrite, PCWriteCond, PCSrc, IorD, MRead, MWrite,
                           IRWrite, RegDs, MtoR, Urw, ALUSrcA, ALUSrcB,
                           AOp, ill_op, st};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset
        #3;
        chk("rst_all_zero", 32'(all_out), 0);
        tick();
        tick();
        chk("rst_held_st", 32'(st), 0);
        rst_n = 1'b1;
        #1;
        chk("release_st", 32'(st), 0);
        tick();
        chk("fetch_st", 32'(st), 1);
        chk("fetch_mread", 32'(MRead), 1);
        chk("fetch_irw", 32'(IRWrite), 1);
        chk("fetch_pcw", 32'(PCWrite), 1);
        chk("fetch_aop", 32'(AOp), 3'b011);
        chk("fetch_srcb", 32'(ALUSrcB), 2'b01);
        chk("fetch_iord", 32'(IorD), 0);
        chk("fetch_ill", 32'(ill_op), 0);
        // fetch wait: strobes gated, state held
        mem_rdy = 1'b0;
        #1;
        chk("fwait_irw", 32'(IRWrite), 0);
        chk("fwait_pcw", 32'(PCWrite), 0);
        chk("fwait_mread", 32'(MRead), 1);
        tick();
        chk("fwait_st", 32'(st), 1);
        mem_rdy = 1'b1;
        op = 6'b100011;
        #1;
        chk("fwait_irw_rdy", 32'(IRWrite), 1);
        // LW zero wait
        tick();
        chk("lw_dec_st", 32'(st), 2);
        chk("lw_dec_srcb", 32'(ALUSrcB), 2'b11);
        chk("lw_dec_aop", 32'(AOp), 3'b011);
        tick();
        chk("lw_adr_st", 32'(st), 3);
        chk("lw_adr_srca", 32'(ALUSrcA), 1);
        chk("lw_adr_srcb", 32'(ALUSrcB), 2'b10);
        tick();
        chk("lw_rd_st", 32'(st), 4);
        chk("lw_rd_mread", 32'(MRead), 1);
        chk("lw_rd_iord", 32'(IorD), 1);
        tick();
        chk("lw_wb_st", 32'(st), 5);
        chk("lw_wb_urw", 32'(Urw), 1);
        chk("lw_wb_mtor", 32'(MtoR), 1);
        chk("lw_wb_regds", 32'(RegDs), 0);
        tick();
        chk("lw_back_st", 32'(st), 1);
        // LW with three wait cycles in MEMRD
        tick();
        tick();
        chk("lww_adr_st", 32'(st), 3);
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lww_rd_st", 32'(st), 4);
            chk("lww_rd_mread", 32'(MRead), 1);
        end
        tick();
        chk("lww_rd4_st", 32'(st), 4);
        mem_rdy = 1'b1;
        tick();
        chk("lww_wb_st", 32'(st), 5);
        tick();
        chk("lww_back_st", 32'(st), 1);
        // SW
        op = 6'b101011;
        tick();
        tick();
        chk("sw_adr_st", 32'(st), 3);
        tick();
        chk("sw_wr_st", 32'(st), 6);
        chk("sw_wr_mwrite", 32'(MWrite), 1);
        chk("sw_wr_mread", 32'(MRead), 0);
        chk("sw_wr_iord", 32'(IorD), 1);
        tick();
        chk("sw_back_st", 32'(st), 1);
        // R-type
        op = 6'b000000;
        tick();
        tick();
        chk("r_ex_st", 32'(st), 7);
        chk("r_ex_aop", 32'(AOp), 3'b010);
        chk("r_ex_srca", 32'(ALUSrcA), 1);
        chk("r_ex_srcb", 32'(ALUSrcB), 2'b00);
        tick();
        chk("r_wb_st", 32'(st), 8);
        chk("r_wb_regds", 32'(RegDs), 1);
        chk("r_wb_urw", 32'(Urw), 1);
        chk("r_wb_mtor", 32'(MtoR), 0);
        tick();
        chk("r_back_st", 32'(st), 1);
        // ORI
        op = 6'b001101;
        tick();
        tick();
        chk("ori_ex_st", 32'(st), 10);
        chk("ori_ex_aop", 32'(AOp), 3'b110);
        chk("ori_ex_srcb", 32'(ALUSrcB), 2'b10);
        tick();
        chk("ori_wb_st", 32'(st), 11);
        chk("ori_wb_urw", 32'(Urw), 1);
        chk("ori_wb_regds", 32'(RegDs), 0);
        tick();
        chk("ori_back_st", 32'(st), 1);
        // SLTI, ADDI, ANDI
        op = 6'b001010;
        tick();
        tick();
        chk("slti_aop", 32'(AOp), 3'b100);
        tick();
        tick();
        op = 6'b001000;
        tick();
        tick();
        chk("addi_aop", 32'(AOp), 3'b011);
        tick();
        tick();
        op = 6'b001100;
        tick();
        tick();
        chk("andi_aop", 32'(AOp), 3'b101);
        tick();
        tick();
        chk("andi_back_st", 32'(st), 1);
        // BEQ
        op = 6'b000100;
        tick();
        chk("beq_dec_st", 32'(st), 2);
        tick();
        chk("beq_br_st", 32'(st), 9);
        chk("beq_pcwc", 32'(PCWriteCond), 1);
        chk("beq_pcsrc", 32'(PCSrc), 2'b01);
        chk("beq_aop", 32'(AOp), 3'b001);
        chk("beq_urw", 32'(Urw), 0);
        tick();
        chk("beq_back_st", 32'(st), 1);
        // J
        op = 6'b000010;
        tick();
        chk("j_dec_st", 32'(st), 2);
        tick();
`ifdef CUNIT_JUMP_EN
        chk("j_st", 32'(st), 12);
        chk("j_pcw", 32'(PCWrite), 1);
        chk("j_pcsrc", 32'(PCSrc), 2'b10);
        tick();
        chk("j_back_st", 32'(st), 1);
        chk("j_ill", 32'(ill_op), 0);
`else
        chk("j_ill_st", 32'(st), 1);
        chk("j_ill_pulse", 32'(ill_op), 1);
`endif
        // generic illegal opcode, pulse lasts one cycle
        op = 6'b111111;
        tick();
        chk("ill_dec_st", 32'(st), 2);
        chk("ill_dec_low", 32'(ill_op), 0);
        tick();
        chk("ill_st", 32'(st), 1);
        chk("ill_pulse", 32'(ill_op), 1);
        op = 6'b000000;
        tick();
        chk("ill_once", 32'(ill_op), 0);
        tick();
        tick();
        tick();
        chk("post_ill_st", 32'(st), 1);
        // reset during MEMWR
        op = 6'b101011;
        tick();
        tick();
        mem_rdy = 1'b0;
        tick();
        chk("rmw_st", 32'(st), 6);
        chk("rmw_mwrite", 32'(MWrite), 1);
        tick();
        chk("rmw_hold_st", 32'(st), 6);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_mwrite", 32'(MWrite), 0);
        chk("rmw_rst_st", 32'(st), 0);
        chk("rmw_rst_all", 32'(all_out), 0);
        mem_rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rmw_rel_st", 32'(st), 0);
        tick();
        chk("rmw_fetch_st", 32'(st), 1);
        chk("rmw_fetch_mread", 32'(MRead), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
